// File: rtl/tft_draw_engine_pkg.sv
// rtl/tft_draw_engine_pkg.sv - shared frame geometry, pixel format and FSM encodings
package tft_draw_engine_pkg;

  localparam int X_RES      = 480;
  localparam int Y_RES      = 272;
  localparam int COORD_BITS = 9;
  localparam int PIXEL_BITS = 9;

  localparam logic [PIXEL_BITS-1:0] CLEAR_COLOR = 9'h1FF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  typedef logic [COORD_BITS-1:0] coord_t;
  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  function automatic logic in_frame(input coord_t x, input coord_t y);
    return (x < COORD_BITS'(X_RES)) && (y < COORD_BITS'(Y_RES));
  endfunction

endpackage

// File: rtl/tft_line_stepper.sv
// rtl/tft_line_stepper.sv - Bresenham line setup and per-cycle stepping datapath
module tft_line_stepper
  import tft_draw_engine_pkg::*;
(
  input  logic                  cclk,
  input  logic                  rstb,
  input  logic                  load,
  input  logic                  step,
  input  logic [COORD_BITS-1:0] x0,
  input  logic [COORD_BITS-1:0] y0,
  input  logic [COORD_BITS-1:0] x1,
  input  logic [COORD_BITS-1:0] y1,
  output logic [COORD_BITS-1:0] x,
  output logic [COORD_BITS-1:0] y,
  output logic                  last
);

  localparam logic [COORD_BITS-1:0] ONE = COORD_BITS'(1);

  logic [COORD_BITS-1:0] x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
  logic signed [10:0]    dx_q, dx_d, dy_q, dy_d;
  logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [11:0]    err_q, err_d;
  logic signed [10:0]    ddx, ddy;
  logic signed [12:0]    e2, dx_e, dy_e;

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xe_q) && (y_q == ye_q);

  always_comb begin
    ddx  = $signed({2'b00, x1}) - $signed({2'b00, x0});
    ddy  = $signed({2'b00, y1}) - $signed({2'b00, y0});
    e2   = $signed({err_q, 1'b0});
    dx_e = $signed({{2{dx_q[10]}}, dx_q});
    dy_e = $signed({{2{dy_q[10]}}, dy_q});

    x_d      = x_q;
    y_d      = y_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    err_d    = err_q;

    if (load) begin
      x_d      = x0;
      y_d      = y0;
      xe_d     = x1;
      ye_d     = y1;
      sx_neg_d = ddx[10];
      sy_neg_d = ddy[10];
      dx_d     = ddx[10] ? -ddx : ddx;
      dy_d     = ddy[10] ? ddy : -ddy;
      err_d    = $signed({dx_d[10], dx_d}) + $signed({dy_d[10], dy_d});
    end else if (step && !last) begin
      // both tests use e2 from the error at the start of the step
      if (e2 >= dy_e) begin
        err_d = err_d + $signed({dy_q[10], dy_q});
        x_d   = sx_neg_q ? x_q - ONE : x_q + ONE;
      end
      if (e2 <= dx_e) begin
        err_d = err_d + $signed({dx_q[10], dx_q});
        y_d   = sy_neg_q ? y_q - ONE : y_q + ONE;
      end
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      x_q      <= '0;
      y_q      <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      err_q    <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: rtl/tft_draw_engine.sv
// rtl/tft_draw_engine.sv - turns touch points into VRAM line writes and full-frame clears
module tft_draw_engine
  import tft_draw_engine_pkg::*;
(
  input  logic                  cclk,
  input  logic                  rstb,
  input  logic                  touch_valid,
  output logic                  touch_ready,
  input  logic [COORD_BITS-1:0] touch_x,
  input  logic [COORD_BITS-1:0] touch_y,
  input  logic [PIXEL_BITS-1:0] touch_color,
  input  logic                  stroke_end,
  input  logic                  clear_req,
  output logic                  wr_ena,
  output logic [COORD_BITS-1:0] wr_x,
  output logic [COORD_BITS-1:0] wr_y,
  output logic [PIXEL_BITS-1:0] wr_data,
  output logic                  clear_done,
  output logic                  busy
);

  localparam logic [COORD_BITS-1:0] ONE    = COORD_BITS'(1);
  localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(X_RES - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(Y_RES - 1);

  logic [1:0]            state_q, state_d;
  logic                  have_prev_q, have_prev_d;
  logic                  keep_q, keep_d;
  logic                  clr_pend_q, clr_pend_d;
  logic                  clr_req_q;
  logic                  clr_last_q, clr_last_d;
  logic [COORD_BITS-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [PIXEL_BITS-1:0] color_q, color_d;
  logic [COORD_BITS-1:0] cx_q, cx_d, cy_q, cy_d;
  logic                  wr_ena_q, wr_ena_d, done_q, done_d;
  logic [COORD_BITS-1:0] wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [PIXEL_BITS-1:0] wr_data_q, wr_data_d;

  logic                  accept, clr_rise, step_last;
  logic [COORD_BITS-1:0] step_x, step_y;

  assign touch_ready = rstb && (state_q == ST_IDLE) && !clr_pend_q;
  assign busy        = (state_q != ST_IDLE);
  assign accept      = touch_valid && touch_ready;
  assign clr_rise    = clear_req && !clr_req_q;

  assign wr_ena     = wr_ena_q;
  assign wr_x       = wr_x_q;
  assign wr_y       = wr_y_q;
  assign wr_data    = wr_data_q;
  assign clear_done = done_q;

  tft_line_stepper u_stepper (
    .cclk (cclk),
    .rstb (rstb),
    .load (state_q == ST_SETUP),
    .step (state_q == ST_DRAW),
    .x0   (x0_q),
    .y0   (y0_q),
    .x1   (x1_q),
    .y1   (y1_q),
    .x    (step_x),
    .y    (step_y),
    .last (step_last)
  );

  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    keep_d      = keep_q;
    clr_pend_d  = clr_pend_q;
    clr_last_d  = clr_last_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    color_d     = color_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    wr_ena_d    = 1'b0;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;

    // a press while already clearing is absorbed by the running sweep
    if (clr_rise && (state_q != ST_CLEAR))
      clr_pend_d = 1'b1;
    if (stroke_end) begin
      have_prev_d = 1'b0;
      keep_d      = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (clr_pend_q) begin
          state_d    = ST_CLEAR;
          cx_d       = '0;
          cy_d       = '0;
          clr_last_d = 1'b0;
        end else if (accept && in_frame(touch_x, touch_y)) begin
          // x1/y1 double as the previous point once the line has finished
          x0_d    = have_prev_q ? x1_q : touch_x;
          y0_d    = have_prev_q ? y1_q : touch_y;
          x1_d    = touch_x;
          y1_d    = touch_y;
          color_d = touch_color;
          keep_d  = !stroke_end;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        wr_ena_d  = 1'b1;
        wr_x_d    = step_x;
        wr_y_d    = step_y;
        wr_data_d = color_q;
        if (step_last) begin
          state_d = ST_IDLE;
          if (keep_q && !stroke_end)
            have_prev_d = 1'b1;
        end
      end
      default: begin
        if (clr_last_q) begin
          done_d      = 1'b1;
          have_prev_d = 1'b0;
          clr_pend_d  = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          wr_ena_d  = 1'b1;
          wr_x_d    = cx_q;
          wr_y_d    = cy_q;
          wr_data_d = CLEAR_COLOR;
          if (cx_q == X_LAST) begin
            cx_d = '0;
            if (cy_q == Y_LAST)
              clr_last_d = 1'b1;
            else
              cy_d = cy_q + ONE;
          end else begin
            cx_d = cx_q + ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      have_prev_q <= 1'b0;
      keep_q      <= 1'b0;
      clr_pend_q  <= 1'b0;
      clr_req_q   <= 1'b0;
      clr_last_q  <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      wr_ena_q    <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      have_prev_q <= have_prev_d;
      keep_q      <= keep_d;
      clr_pend_q  <= clr_pend_d;
      clr_req_q   <= clear_req;
      clr_last_q  <= clr_last_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      wr_ena_q    <= wr_ena_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_tft_draw_engine.sv
// tb/tb_tft_draw_engine.sv - randomized self-checking bench for tft_draw_engine
module tb_tft_draw_engine;

  localparam int XR      = 480;
  localparam int YR      = 272;
  localparam int NPIX    = XR * YR;
  localparam int CLR_COL = 'h1FF;

  logic       cclk = 1'b0;
  logic       rstb = 1'b0;
  logic       touch_valid = 1'b0;
  logic       stroke_end = 1'b0;
  logic       clear_req = 1'b0;
  logic [8:0] touch_x = '0, touch_y = '0, touch_color = '0;
  logic       touch_ready, wr_ena, clear_done, busy;
  logic [8:0] wr_x, wr_y, wr_data;

  tft_draw_engine dut (
    .cclk        (cclk),
    .rstb        (rstb),
    .touch_valid (touch_valid),
    .touch_ready (touch_ready),
    .touch_x     (touch_x),
    .touch_y     (touch_y),
    .touch_color (touch_color),
    .stroke_end  (stroke_end),
    .clear_req   (clear_req),
    .wr_ena      (wr_ena),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .clear_done  (clear_done),
    .busy        (busy)
  );

  always #5 cclk = ~cclk;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [8:0] d;
  } wr_t;

  wr_t cap[$];
  wr_t exp_q[$];
  int  cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, done_cnt = 0, done_cyc = 0;
  int  n_checks = 0, n_pass = 0;
  bit  m_have_prev = 1'b0;
  int  m_px = 0, m_py = 0;

  always @(posedge cclk) cyc <= cyc + 1;

  always @(negedge cclk) begin
    if (wr_ena) begin
      if (cap.size() == 0) first_wr_cyc <= cyc;
      cap.push_back({wr_x, wr_y, wr_data});
      last_wr_cyc <= cyc;
    end
    if (clear_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void model_line(input int x0, input int y0, input int x1, input int y1, input int c);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_q.delete();
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    for (int k = 0; k < 2048; k++) begin
      exp_q.push_back({9'(x), 9'(y), 9'(c)});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  function automatic void model_point(input int x, input int y, input int c);
    exp_q.delete();
    if (x >= XR || y >= YR) return;
    if (m_have_prev) model_line(m_px, m_py, x, y, c);
    else             model_line(x, y, x, y, c);
    m_px = x;
    m_py = y;
    m_have_prev = 1'b1;
  endfunction

  function automatic int line_errs(input int off);
    int e = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (off + i >= cap.size() || cap[off + i] != exp_q[i]) e++;
    return e;
  endfunction

  function automatic int clear_errs(input int off);
    int  e = 0;
    wr_t w;
    for (int i = 0; i < NPIX; i++) begin
      w = {9'(i % XR), 9'(i / XR), 9'(CLR_COL)};
      if (off + i >= cap.size() || cap[off + i] != w) e++;
    end
    return e;
  endfunction

  task automatic send_point(input int x, input int y, input int c, input int budget, output int hs);
    int n = 0;
    @(negedge cclk);
    touch_valid = 1'b1;
    touch_x     = 9'(x);
    touch_y     = 9'(y);
    touch_color = 9'(c);
    while (!touch_ready && n < budget) begin
      @(negedge cclk);
      n++;
    end
    if (!touch_ready) begin
      chk("hs_timeout", 0, 1);
      touch_valid = 1'b0;
      hs = -1;
      return;
    end
    @(posedge cclk);
    #1 touch_valid = 1'b0;
    @(negedge cclk);
    hs = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge cclk);
      n++;
    end
    if (busy) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge cclk);
  endtask

  task automatic pulse_stroke_end();
    @(negedge cclk);
    stroke_end = 1'b1;
    @(negedge cclk);
    stroke_end = 1'b0;
    m_have_prev = 1'b0;
  endtask

  task automatic do_point(input string tag, input int x, input int y, input int c);
    int hs;
    model_point(x, y, c);
    cap.delete();
    send_point(x, y, c, 50, hs);
    wait_idle(2000);
    chk({tag, "_n"}, cap.size(), exp_q.size());
    chk({tag, "_px"}, line_errs(0), 0);
    if (exp_q.size() > 0) chk({tag, "_lat"}, first_wr_cyc - hs, 2);
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge cclk);
      n++;
    end
    if (done_cnt == base) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int base, hs, len, sz, n, rx, ry;

    // reset values
    repeat (2) @(negedge cclk);
    chk("rst_wr_ena", int'(wr_ena), 0);
    chk("rst_wr_x", int'(wr_x), 0);
    chk("rst_wr_y", int'(wr_y), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_touch_ready", int'(touch_ready), 0);
    rstb = 1'b1;
    @(negedge cclk);
    chk("ready_after_rst", int'(touch_ready), 1);

    // single-cycle clear request -> full sweep
    cap.delete();
    base = done_cnt;
    clear_req = 1'b1;
    @(negedge cclk);
    clear_req = 1'b0;
    wait_done(base, 140000);
    repeat (3) @(negedge cclk);
    chk("t1_count", cap.size(), NPIX);
    chk("t1_pixels", clear_errs(0), 0);
    chk("t1_first_x", int'(cap[0].x), 0);
    chk("t1_first_y", int'(cap[0].y), 0);
    chk("t1_last_x", int'(cap[cap.size() - 1].x), XR - 1);
    chk("t1_last_y", int'(cap[cap.size() - 1].y), YR - 1);
    chk("t1_last_d", int'(cap[cap.size() - 1].d), CLR_COL);
    chk("t1_consecutive", last_wr_cyc - first_wr_cyc + 1, NPIX);
    chk("t1_done_pulses", done_cnt - base, 1);
    chk("t1_done_after_last", done_cyc - last_wr_cyc, 1);
    chk("t1_ready", int'(touch_ready), 1);
    m_have_prev = 1'b0;

    // first point of a stroke is a single pixel
    do_point("t2", 10, 20, 'h1C0);
    chk("t2_x", int'(cap[0].x), 10);
    chk("t2_y", int'(cap[0].y), 20);

    pulse_stroke_end();
    do_point("t3a", 0, 0, 'h007);
    do_point("t3b", 5, 2, 'h007);
    chk("t3_n", cap.size(), 6);
    chk("t3_w2_x", int'(cap[2].x), 2);
    chk("t3_w2_y", int'(cap[2].y), 1);
    chk("t3_ready", int'(touch_ready), 1);

    pulse_stroke_end();
    do_point("t4a", 100, 50, 'h038);
    do_point("t4b", 98, 55, 'h038);
    chk("t4_n", cap.size(), 6);
    chk("t4_end_x", int'(cap[cap.size() - 1].x), 98);
    chk("t4_end_y", int'(cap[cap.size() - 1].y), 55);

    // random strokes, occasional pen lifts and out-of-frame points
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) pulse_stroke_end();
      rx = $urandom_range(0, 500);
      ry = $urandom_range(0, 290);
      do_point($sformatf("rnd%0d", i), rx, ry, int'($urandom_range(0, 511)));
    end

    // clear held during DRAW with a pen lift, then an out-of-frame point
    pulse_stroke_end();
    do_point("t5a", 300, 10, 'h0AA);
    model_point(20, 200, 'h155);
    len = exp_q.size();
    cap.delete();
    base = done_cnt;
    send_point(20, 200, 'h155, 50, hs);
    @(negedge cclk);
    clear_req = 1'b1;
    @(negedge cclk);
    stroke_end = 1'b1;
    @(negedge cclk);
    stroke_end = 1'b0;
    @(negedge cclk);
    clear_req = 1'b0;
    m_have_prev = 1'b0;
    send_point(480, 0, 'h100, 140000, hs);
    repeat (4) @(negedge cclk);
    chk("t5_done_pulses", done_cnt - base, 1);
    chk("t5_count", cap.size(), len + NPIX);
    chk("t5_line", line_errs(0), 0);
    chk("t5_clear", clear_errs(len), 0);
    chk("t5_hs_after_done", int'(hs > done_cyc), 1);
    chk("t5_busy", int'(busy), 0);

    // asynchronous reset in the middle of a clear
    cap.delete();
    base = done_cnt;
    @(negedge cclk);
    clear_req = 1'b1;
    @(negedge cclk);
    clear_req = 1'b0;
    n = 0;
    while (cap.size() < 1000 && n < 5000) begin
      @(negedge cclk);
      n++;
    end
    chk("t6_started", int'(cap.size() >= 1000), 1);
    #2 rstb = 1'b0;
    #1;
    chk("t6_wr_ena", int'(wr_ena), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_ready_low", int'(touch_ready), 0);
    sz = cap.size();
    repeat (3) @(negedge cclk);
    rstb = 1'b1;
    m_have_prev = 1'b0;
    repeat (3) @(negedge cclk);
    chk("t6_ready", int'(touch_ready), 1);
    chk("t6_idle", int'(busy), 0);
    chk("t6_no_resume", cap.size(), sz);
    chk("t6_no_done", done_cnt - base, 0);
    do_point("t6p", 200, 100, 'h049);
    chk("t6_single", cap.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
